// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between two requesters.
// Round-robin on ties, bounded hold while the other side waits.
module mem_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } owner_t;

  localparam logic [4:0] HOLD_LIM = 5'(MAX_HOLD);

  owner_t     owner;
  owner_t     other;
  logic       last;
  logic [3:0] hold_cnt;
  logic [4:0] hold_inc;
  logic       own_req;
  logic       oth_req;

  assign grant0   = (owner == P0);
  assign grant1   = (owner == P1);
  assign other    = grant0 ? P1 : P0;
  assign own_req  = grant0 ? req0 : req1;
  assign oth_req  = grant0 ? req1 : req0;
  assign hold_inc = {1'b0, hold_cnt} + 5'd1;

  // last: 0 = P0 released most recently, 1 = P1
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      owner    <= NONE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      unique case (owner)
        NONE: begin
          hold_cnt <= '0;
          if (req0 && (!req1 || last))
            owner <= P0;
          else if (req1)
            owner <= P1;
        end
        P0, P1: begin
          if (!own_req ||
              (oth_req && hold_inc >= HOLD_LIM)) begin
            owner    <= oth_req ? other : NONE;
            last     <= grant1;
            hold_cnt <= '0;
          end else if (!oth_req &&
                       hold_inc >= HOLD_LIM) begin
            hold_cnt <= HOLD_LIM[3:0];
          end else begin
            hold_cnt <= hold_inc[3:0];
          end
        end
        default: owner <= NONE;
      endcase
    end
  end

  assign ack0 = grant0 & req0;
  assign ack1 = grant1 & req1;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    unique case (1'b1)
      ack0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_write = we0;
        mem_read  = !we0;
      end
      ack1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_write = we1;
        mem_read  = !we1;
      end
      default: ;
    endcase
  end

  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plan checks plus random traffic
// against a port-indexed reference model and memory image.
module tb_mem_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       rq [2];
  logic       wr [2];
  logic [3:0] ad [2];
  logic [7:0] wd [2];
  logic       g0, g1, a0, a1;
  logic [7:0] rd0, rd1;
  logic [3:0] maddr;
  logic       mw, mr;
  logic [7:0] mwd, mrd;

  logic [7:0] mem     [16];
  logic [7:0] ref_mem [16];

  int vectors = 0;
  int errors  = 0;

  int m_own;
  int m_last;
  int m_cnt;

  logic       acked [2];
  logic       obs_a0, obs_a1, obs_mr;
  logic [7:0] obs_rd0, obs_rd1;

  always #5 clk = ~clk;

  assign mrd = mem[maddr];

  mem_arbiter #(
    .ADDR_W(4), .DATA_W(8), .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk), .clr(clr),
    .req0(rq[0]), .req1(rq[1]),
    .we0(wr[0]), .we1(wr[1]),
    .addr0(ad[0]), .addr1(ad[1]),
    .wdata0(wd[0]), .wdata1(wd[1]),
    .grant0(g0), .grant1(g1),
    .ack0(a0), .ack1(a1),
    .rdata0(rd0), .rdata1(rd1),
    .mem_addr(maddr), .mem_write(mw),
    .mem_read(mr), .mem_wdata(mwd),
    .mem_rdata(mrd)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_last = 1;
    m_cnt  = 0;
  endtask

  // One clock: check at negedge, advance model at posedge.
  task automatic step();
    logic       ek [2];
    logic [3:0] ea;
    logic [7:0] ed;
    logic       ew, er;
    int p, o;
    @(negedge clk);
    ea = '0; ed = '0; ew = 1'b0; er = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ek[i] = (m_own == i) && rq[i];
      if (ek[i]) begin
        ea = ad[i]; ed = wd[i];
        ew = wr[i]; er = !wr[i];
      end
    end
    check("grant0", 32'(g0), 32'(m_own == 0));
    check("grant1", 32'(g1), 32'(m_own == 1));
    check("ack0", 32'(a0), 32'(ek[0]));
    check("ack1", 32'(a1), 32'(ek[1]));
    check("mem_write", 32'(mw), 32'(ew));
    check("mem_read", 32'(mr), 32'(er));
    check("mem_addr", 32'(maddr), 32'(ea));
    check("mem_wdata", 32'(mwd), 32'(ed));
    if (ek[0] && !wr[0])
      check("rdata0", 32'(rd0), 32'(ref_mem[ad[0]]));
    if (ek[1] && !wr[1])
      check("rdata1", 32'(rd1), 32'(ref_mem[ad[1]]));
    obs_a0 = a0; obs_a1 = a1; obs_mr = mr;
    obs_rd0 = rd0; obs_rd1 = rd1;
    acked = ek;
    @(posedge clk);
    if (mw) mem[maddr] = mwd;
    if (clr) begin
      for (int i = 0; i < 2; i++)
        if (ek[i] && wr[i]) ref_mem[ad[i]] = wd[i];
      if (m_own < 0) begin
        if (rq[0] && rq[1]) m_own = 1 - m_last;
        else if (rq[0]) m_own = 0;
        else if (rq[1]) m_own = 1;
        m_cnt = 0;
      end else begin
        p = m_own;
        o = 1 - p;
        if (!rq[p]) begin
          m_own = rq[o] ? o : -1;
          m_last = p;
          m_cnt = 0;
        end else if (!rq[o]) begin
          m_cnt = (m_cnt + 1 > MAXH) ? MAXH : m_cnt + 1;
        end else if (m_cnt + 1 < MAXH) begin
          m_cnt = m_cnt + 1;
        end else begin
          m_own = o;
          m_last = p;
          m_cnt = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    model_reset();
    step();
    step();
    clr = 1'b1;
  endtask

  task automatic new_access(input int p);
    rq[p] = 1'b1;
    wr[p] = 1'($urandom);
    ad[p] = 4'($urandom);
    wd[p] = 8'($urandom);
  endtask

  initial begin
    int n, t0, t1, run0;
    logic prev0, handoff;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[3] = 8'hA5;
    ref_mem[3] = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b1; wr[i] = 1'b1;
      ad[i] = 4'd7; wd[i] = 8'hFF;
    end

    // reset with both ports requesting writes
    clr = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) step();

    // single read of mem[3]
    rq[1] = 1'b0;
    wr[0] = 1'b0; ad[0] = 4'd3;
    clr = 1'b1;
    step();
    check("rd_grant0", 32'(g0), 32'd1);
    step();
    check("rd_ack0", 32'(obs_a0), 32'd1);
    check("rd_data", 32'(obs_rd0), 32'hA5);
    check("rd_mread", 32'(obs_mr), 32'd1);
    rq[0] = 1'b0;
    step();
    check("rd_mread_off", 32'(obs_mr), 32'd0);

    // P1 write then read of addr 9
    rq[1] = 1'b1; wr[1] = 1'b1;
    ad[1] = 4'd9; wd[1] = 8'h3C;
    n = 0;
    do begin step(); n++; end
    while (!acked[1] && n < 8);
    check("wr_ack1", 32'(obs_a1), 32'd1);
    wr[1] = 1'b0;
    step();
    check("rb_ack1", 32'(obs_a1), 32'd1);
    check("rb_data", 32'(obs_rd1), 32'h3C);
    rq[1] = 1'b0;
    step();
    step();

    // simultaneous requests after reset
    do_reset();
    rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 4'd1;
    rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = 4'd2;
    t0 = -1; t1 = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_a0 && t0 < 0) t0 = c;
      if (obs_a1 && t1 < 0) t1 = c;
      if (acked[0]) rq[0] = 1'b0;
      if (acked[1]) rq[1] = 1'b0;
    end
    check("tie_p0_cycle", 32'(t0), 32'd1);
    check("tie_p1_cycle", 32'(t1), 32'd3);

    // hold limit: P1 arrives during P0's 2nd access
    rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 4'($urandom);
    run0 = 0; prev0 = 1'b0; handoff = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs_a1) begin
        handoff = prev0;
        break;
      end
      prev0 = obs_a0;
      if (obs_a0) begin
        run0++;
        ad[0] = 4'($urandom);
        if (run0 == 1) rq[1] = 1'b1;
      end
    end
    check("hold_run", 32'(run0), 32'(MAXH));
    check("hold_nobubble", 32'(handoff), 32'd1);
    rq[0] = 1'b0; rq[1] = 1'b0;
    step(); step(); step();

    // reset during a P1 write to addr 5
    rq[1] = 1'b1; wr[1] = 1'b1;
    ad[1] = 4'd5; wd[1] = ~ref_mem[5];
    n = 0;
    while (m_own != 1 && n < 6) begin step(); n++; end
    check("mw_grant1", 32'(g1), 32'd1);
    #2;
    check("mw_ack_live", 32'(a1), 32'd1);
    clr = 1'b0;
    model_reset();
    #1;
    check("mw_ack_drop", 32'(a1), 32'd0);
    check("mw_write_drop", 32'(mw), 32'd0);
    check("mw_grant_drop", 32'(g1), 32'd0);
    @(posedge clk);
    if (mw) mem[maddr] = mwd;
    #1;
    check("mw_mem5", 32'(mem[5]), 32'(ref_mem[5]));
    step();
    clr = 1'b1;
    rq[1] = 1'b0;
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (rq[p]) begin
          if (acked[p]) begin
            if ($urandom % 4 != 0) new_access(p);
            else rq[p] = 1'b0;
          end else if (m_own != p && $urandom % 8 == 0) begin
            rq[p] = 1'b0;
          end
        end else if ($urandom % 3 == 0) begin
          new_access(p);
        end
      end
    end
    for (int i = 0; i < 16; i++)
      check("mem_image", 32'(mem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 16x8 program/data memory between the CPU and a second requester, such as a program loader or debug port. It sits between both masters and the memory array. It grants one owner at a time, with round-robin tie-breaking and a bounded hold limit. It drives the memory's address, write strobe and write data. The memory itself is unchanged: reads are combinational, and writes are synchronous on the rising edge of `clk`.

## Interface
- `ADDR_W`, default 4, memory address width.
- `DATA_W`, default 8, memory data width.
- `MAX_HOLD`, default 4, maximum back-to-back accesses by one owner while the other port is requesting. Legal range is 1..15.

- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1 each  port requests an access this cycle.
- `we0`, `we1`  in  1 each  1 = write, 0 = read; qualified by req.
- `addr0`, `addr1`  in  ADDR_W each  access address.
- `wdata0`, `wdata1`  in  DATA_W each  write data.
- `grant0`, `grant1`  out  1 each  registered: the port currently owns the memory.
- `ack0`, `ack1`  out  1 each  combinational: an access completes in this cycle.
- `rdata0`, `rdata1`  out  DATA_W each  read data, valid when the matching ack is high with we=0.
- `mem_addr`  out  ADDR_W  address to memory.
- `mem_write`  out  1  memory write strobe.
- `mem_read`  out  1  memory read strobe.
- `mem_wdata`  out  DATA_W  data to memory.
- `mem_rdata`  in  DATA_W  combinational read data from memory.

## Operation
- State registers:
  - `owner` ∈ {NONE, P0, P1}; `grant0` = (owner==P0), `grant1` = (owner==P1).
  - `last` ∈ {P0, P1}: the most recent owner to release.
  - `hold_cnt`, 4-bit.
- Access rule: `ackx` = grantx & reqx. Each cycle with `ackx` high is exactly one memory access.
- Memory drive:
  - When ack0 or ack1 is high, `mem_addr`/`mem_wdata` come from the owning port; otherwise both are 0.
  - `mem_write` = ack & we; `mem_read` = ack & ~we.
- `rdata0` and `rdata1` both mirror `mem_rdata`. Requesters qualify the data with their own ack.
- Transitions at each rising edge:
  - **NONE, one req high:** owner ← that port; hold_cnt ← 0.
  - **NONE, both high:** owner ← the port ≠ last; hold_cnt ← 0.
  - **NONE, neither high:** stay in NONE.
  - **Px, reqx=1, other req=0:** stay; hold_cnt ← min(hold_cnt+1, MAX_HOLD).
  - **Px, reqx=1, other req=1, hold_cnt+1 < MAX_HOLD:** stay; hold_cnt+1.
  - **Px, reqx=1, other req=1, hold_cnt+1 ≥ MAX_HOLD:** owner ← other; last ← Px; hold_cnt ← 0. The access this cycle still completes.
  - **Px, reqx=0:** release. owner ← other if other req=1, else NONE; last ← Px; hold_cnt ← 0.
- Requester protocol:
  - Hold req/we/addr/wdata stable until the edge at which ack was high.
  - After that edge, either present the next access with req still high, or drop req.
  - Dropping req while not granted is legal; the request is simply withdrawn.
- The arbiter never issues an ack to a port whose req is low. It never asserts `mem_write` and `mem_read` together.

## Timing
- Reset (clr=0, async): owner=NONE, last=P1 (so P0 wins the first tie), hold_cnt=0.
- While in reset, all outputs are 0: grants, acks, mem_write, mem_read, mem_addr, mem_wdata. rdata follows mem_rdata.
- Grant latency: req high while in NONE → grant registered at the next edge → ack in the following cycle. The first access therefore completes 2 edges after req is first sampled.
- Back-to-back accesses by the current owner: one per cycle, with no bubble.
- Handoff on hold limit: no bubble. The new owner is acked in the cycle after the old owner's last ack.
- Release by dropping req costs one idle cycle (grant high, ack low) before the handoff.
- Write timing: the memory updates at the edge that ends the ack cycle. A read of the same address in the next cycle returns the new data.
- Reset mid-operation: the in-flight ack and mem_write drop immediately (asynchronously); no write commits at or after assertion.
- Deassertion of clr is sampled at the following edge.

## Test plan
- **Reset:** clr=0 with req0=req1=1 → every output is 0, and mem_write never pulses.
- **Single read:** release clr; P0 reads addr0=3 where mem[3]=8'hA5 → grant0 rises after the first edge; ack0=1 and rdata0=8'hA5 in the next cycle; mem_read=1 only in that cycle.
- **Write then read:** P1 writes 8'h3C to addr 9 with req held, then reads addr 9 → ack1 on 2 consecutive cycles; the read returns 8'h3C; grant1 is held throughout.
- **Tie and round-robin:** req0 and req1 rise together after reset, each for 1 access → P0 is acked first, then a 1-cycle release gap, then P1.
- **Hold limit (MAX_HOLD=4):** P0 requests continuously; P1 raises req during P0's 2nd access → P0 receives exactly 4 consecutive acks, then ack1 in the very next cycle.
- **Reset mid-write:** assert clr during P1's write ack to addr 5 → ack1 and mem_write fall immediately; mem[5] is unchanged; owner returns to NONE.
